// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its pending-operand scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Index of the register that can be hard-wired to zero.
  localparam int ZERO_ADDR = 0;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard: issue marks a destination register as
// pending, write-back clears it, flush clears everything. Also keeps a
// registered count of pending registers.
module rf_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      mark_en_i,
  input  logic [ADDR_W-1:0]         mark_addr_i,
  input  logic                      clr_en_i,
  input  logic [ADDR_W-1:0]         clr_addr_i,
  output logic [(1<<ADDR_W)-1:0]    pending_o,
  output logic [ADDR_W:0]           pend_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] pendCnt_q, pendCnt_d;
  logic             markSet, wbClr;

  // Next pending vector: flush beats everything, a mark beats a same-address clear.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
      if (mark_en_i) pending_d[mark_addr_i] = 1'b1;
    end
    if (ZERO_REG) pending_d[0] = 1'b0;
  end

  // Count only real transitions so re-marks and clears of idle registers are free.
  always_comb begin
    markSet   = mark_en_i && !pending_q[mark_addr_i] && !(ZERO_REG && mark_addr_i == ZERO_A);
    wbClr     = clr_en_i && pending_q[clr_addr_i] && !(mark_en_i && mark_addr_i == clr_addr_i);
    pendCnt_d = pendCnt_q + CNT_W'(markSet) - CNT_W'(wbClr);
    if (flush_i) pendCnt_d = '0;
  end

  // Scoreboard state, cleared immediately on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q <= '0;
      pendCnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      pendCnt_q <= pendCnt_d;
    end
  end

  assign pending_o  = pending_q;
  assign pend_cnt_o = pendCnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with optional write-to-read bypass,
// optional hard-wired zero register and a pending-operand scoreboard that
// lets the control FSM stall on operands not yet written back.
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wrEn, byp1, byp2;

  // A write to the hard-wired zero register is dropped for storage and forwarding alike.
  always_comb begin
    wrEn = WE3 && !(ZERO_REG && A3 == ZERO_A);
    byp1 = BYPASS && wrEn && (A1 == A3);
    byp2 = BYPASS && wrEn && (A2 == A3);
  end

  // Register array; all entries clear on reset, register 0 is never written when hard-wired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wrEn) begin
      regs_q[A3] <= WD3;
    end
  end

  // Read muxes with forwarding; outputs are held at zero while reset is asserted.
  always_comb begin
    RD1 = regs_q[A1];
    RD2 = regs_q[A2];
    if (ZERO_REG && A1 == ZERO_A) RD1 = '0;
    if (ZERO_REG && A2 == ZERO_A) RD2 = '0;
    if (byp1) RD1 = WD3;
    if (byp2) RD2 = WD3;
    if (reset) begin
      RD1 = '0;
      RD2 = '0;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk_i      (clk),
    .reset_i    (reset),
    .flush_i    (flush),
    .mark_en_i  (mark_en),
    .mark_addr_i(mark_addr),
    .clr_en_i   (WE3),
    .clr_addr_i (A3),
    .pending_o  (pending),
    .pend_cnt_o (pend_cnt)
  );

  // An operand being written back this cycle is already available through the bypass.
  always_comb begin
    busy1 = pending[A1] && !byp1 && !reset;
    busy2 = pending[A2] && !byp2 && !reset;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal
// expectations followed by randomized traffic checked against an
// array-based reference model on every cycle.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          WE3;
  reg_addr_t     A1, A2, A3, mark_addr;
  logic [DW-1:0] WD3, RD1, RD2;
  logic          mark_en, flush, busy1, busy2;
  logic [AW:0]   pend_cnt;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  logic [DW-1:0] mRegs [DEPTH];
  bit            mPend [DEPTH];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2), .mark_en(mark_en), .mark_addr(mark_addr), .flush(flush),
    .busy1(busy1), .busy2(busy2), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays of register values and pending flags.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mRegs[i] = '0;
        mPend[i] = 1'b0;
      end
    end else begin
      if (WE3 && A3 != 0) mRegs[A3] = WD3;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) mPend[i] = 1'b0;
      end else begin
        if (WE3) mPend[A3] = 1'b0;
        if (mark_en && mark_addr != 0) mPend[mark_addr] = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] expRd(input reg_addr_t a);
    if (reset) return '0;
    if (WE3 && a == A3 && A3 != 0) return WD3;
    if (a == 0) return '0;
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input reg_addr_t a);
    if (reset) return 1'b0;
    if (WE3 && a == A3 && A3 != 0) return 1'b0;
    return mPend[a];
  endfunction

  function automatic int expCnt();
    int c = 0;
    if (reset) return 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mPend[i]);
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input int a3, input logic [DW-1:0] wd,
                               input int a1, input int a2, input logic mk, input int maddr,
                               input logic fl);
    @(posedge clk);
    #1;
    WE3 = we; A3 = reg_addr_t'(a3); WD3 = wd;
    A1 = reg_addr_t'(a1); A2 = reg_addr_t'(a2);
    mark_en = mk; mark_addr = reg_addr_t'(maddr); flush = fl;
  endtask

  function automatic int randAddr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, DEPTH - 1));
    return int'($urandom_range(0, 7));
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("RD1", RD1, expRd(A1));
      checkOutput("RD2", RD2, expRd(A2));
      checkOutput("busy1", DW'(busy1), DW'(expBusy(A1)));
      checkOutput("busy2", DW'(busy2), DW'(expBusy(A2)));
      checkOutput("pend_cnt", DW'(pend_cnt), DW'(expCnt()));
    end
  end

  initial begin
    reset = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    mark_en = 1'b0; mark_addr = '0; flush = 1'b0;
    #1 reset = 1'b1;
    checkEn = 1'b1;
    #1;
    checkOutput("reset RD1", RD1, '0);
    checkOutput("reset pend_cnt", DW'(pend_cnt), '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Write then read, with same-cycle bypass.
    applyStimulus(1, 7, 32'h12345678, 0, 7, 0, 0, 0);
    #2 checkOutput("bypass RD2", RD2, 32'h12345678);
    applyStimulus(0, 0, 0, 7, 7, 0, 0, 0);
    #2 checkOutput("array RD1", RD1, 32'h12345678);

    // Zero register ignores writes and marks.
    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0);
    #2 checkOutput("zero RD1 bypass", RD1, '0);
    checkOutput("zero busy1", DW'(busy1), '0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("zero RD1", RD1, '0);
    checkOutput("zero pend_cnt", DW'(pend_cnt), '0);

    // Mark r3, then write it back.
    applyStimulus(0, 0, 0, 3, 0, 1, 3, 0);
    applyStimulus(0, 0, 0, 3, 0, 0, 0, 0);
    #2 checkOutput("mark busy1", DW'(busy1), 1);
    checkOutput("mark pend_cnt", DW'(pend_cnt), 1);
    applyStimulus(1, 3, 32'h000000A5, 3, 0, 0, 0, 0);
    #2 checkOutput("wb busy1", DW'(busy1), 0);
    checkOutput("wb RD1", RD1, 32'h000000A5);
    applyStimulus(0, 0, 0, 3, 0, 0, 0, 0);
    #2 checkOutput("wb pend_cnt", DW'(pend_cnt), 0);

    // Mark and clear r9 together, then mark r4 while clearing r9.
    applyStimulus(0, 0, 0, 9, 0, 1, 9, 0);
    applyStimulus(1, 9, 32'h99, 9, 0, 1, 9, 0);
    #2 checkOutput("r9 pend_cnt", DW'(pend_cnt), 1);
    applyStimulus(1, 9, 32'h99, 9, 0, 1, 4, 0);
    #2 checkOutput("r9 stays pend_cnt", DW'(pend_cnt), 1);
    applyStimulus(0, 0, 0, 4, 9, 0, 0, 0);
    #2 checkOutput("r4 busy1", DW'(busy1), 1);
    checkOutput("r9 busy2", DW'(busy2), 0);
    checkOutput("swap pend_cnt", DW'(pend_cnt), 1);

    // Six pending, then flush with a competing mark.
    for (int r = 10; r < 15; r++) applyStimulus(0, 0, 0, 0, 0, 1, r, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 2, 1);
    #2 checkOutput("six pend_cnt", DW'(pend_cnt), 6);
    applyStimulus(0, 0, 0, 2, 4, 0, 0, 0);
    #2 checkOutput("flush pend_cnt", DW'(pend_cnt), 0);
    checkOutput("flush busy1", DW'(busy1), 0);
    checkOutput("flush busy2", DW'(busy2), 0);

    // Reset mid-run.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 1, 6, 0);
    applyStimulus(0, 0, 0, 5, 6, 0, 0, 0);
    #2 checkOutput("pre-reset RD1", RD1, 32'hDEADBEEF);
    checkOutput("pre-reset pend_cnt", DW'(pend_cnt), 1);
    reset = 1'b1;
    #1 checkOutput("mid reset RD1", RD1, '0);
    checkOutput("mid reset pend_cnt", DW'(pend_cnt), '0);
    @(negedge clk);
    #1 reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int a3;
      a3 = randAddr();
      applyStimulus(logic'($urandom_range(0, 1)), a3, $urandom,
                    ($urandom_range(0, 3) == 0) ? a3 : randAddr(), randAddr(),
                    logic'($urandom_range(0, 1)), randAddr(),
                    logic'($urandom_range(0, 31) == 0));
      if (n % 401 == 400) begin
        #2 reset = 1'b1;
        #1 checkOutput("rand reset RD1", RD1, '0);
        checkOutput("rand reset pend_cnt", DW'(pend_cnt), '0);
        @(negedge clk);
        #1 reset = 1'b0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1 checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the multi-cycle CPU datapath, with two read ports, one write port, optional write-to-read bypass and an optional hard-wired zero register. It adds a per-register pending scoreboard: the controller marks a destination register when an instruction issues, the write-back clears the mark, and the read ports flag busy operands so the control FSM can stall. It sits between the instruction decode stage and the ALU operand registers and replaces the fixed 32x32 register file.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- ZERO_REG, 1: 1 = register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.

- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high; clears all registers and all pending bits.
- WE3, in, 1: write enable.
- A1, in, ADDR_W: read address, port 1.
- A2, in, ADDR_W: read address, port 2.
- A3, in, ADDR_W: write address.
- WD3, in, DATA_W: write data.
- RD1, out, DATA_W: read data, port 1 (combinational).
- RD2, out, DATA_W: read data, port 2 (combinational).
- mark_en, in, 1: set the pending bit of mark_addr.
- mark_addr, in, ADDR_W: register to mark as pending.
- flush, in, 1: synchronously clear all pending bits.
- busy1, out, 1: the A1 operand is pending.
- busy2, out, 1: the A2 operand is pending.
- pend_cnt, out, ADDR_W+1: number of pending registers.

## Operation
- Write: on a posedge with WE3=1, reg[A3] <= WD3. A write to address 0 is discarded when ZERO_REG=1.
- Read: RDn = reg[An]. When ZERO_REG=1 and An=0, RDn = 0.
- Bypass: when BYPASS=1, WE3=1, An=A3 and the address is not a discarded zero-register write, RDn = WD3.
- Scoreboard pending[i] next state, in priority order:
  - reset → 0.
  - flush → 0. flush overrides mark_en and write-back.
  - mark_en and mark_addr=i → 1. A mark wins over a same-cycle clear to the same address, because a new producer has issued.
  - WE3 and A3=i → 0.
  - Otherwise hold.
- pending[0] is held at 0 when ZERO_REG=1.
- busyn = pending[An], except forced to 0 when BYPASS=1 and a same-cycle write to An clears it.
- pend_cnt is a registered count kept consistent with pending, updated each cycle:
  - +1 for a set of a clear bit.
  - −1 for a clear of a set bit.
  - Net 0 for simultaneous set and clear on different addresses.
  - 0 after flush or reset.
  - Range 0..2**ADDR_W (or 2**ADDR_W−1 with ZERO_REG=1). It never wraps.
- Re-marking an already pending register changes nothing and leaves pend_cnt unchanged.

## Timing
- Reset values: every register 0, every pending bit 0, pend_cnt = 0. While reset is high, RD1/RD2 = 0 and busy1/busy2 = 0. Assertion takes effect immediately; deassertion is synchronous to clk.
- Write latency: the data is visible through the array in the cycle after the write edge, and in the same cycle through bypass when enabled.
- Mark latency: busy asserts in the cycle after the mark_en edge.
- Clear latency: busy deasserts in the same cycle as the write-back when BYPASS=1, otherwise in the following cycle.
- Reset mid-operation: a write or mark in flight is lost. There is no partial update.

## Structure
- Shared package regfile_pkg holds:
  - the default DATA_W and ADDR_W constants;
  - the ZERO_ADDR constant;
  - a typedef for the register address.
- One sub-module, rf_scoreboard, holds the pending vector, the priority logic and pend_cnt. The register array, read muxes and bypass stay in regfile_sb.

## Test plan
- Reset mid-run: write 0xDEADBEEF to r5, assert reset for half a cycle → RD1 (A1=5) = 0 immediately and pend_cnt = 0.
- Write then read: WE3=1, A3=7, WD3=0x12345678. Next cycle with A1=7 → RD1 = 0x12345678. In the same cycle with A2=7 and BYPASS=1 → RD2 = 0x12345678.
- Zero register: write 0xFFFFFFFF to r0 and mark r0 → RD1 (A1=0) = 0, busy1 = 0, pend_cnt unchanged.
- Scoreboard: mark r3 → next cycle busy1 = 1 for A1=3 and pend_cnt = 1. Write-back to r3 → busy1 = 0 in the same cycle and pend_cnt = 0 the next cycle.
- Simultaneous mark and clear on r9 (r9 pending) → r9 stays pending and pend_cnt unchanged. Mark r4 while clearing r9 → pend_cnt unchanged, r4 pending.
- flush with 6 registers pending and mark_en=1 on r2 → next cycle pend_cnt = 0, all busy = 0.
